// File: rtl/dice_roll_capture.sv
// -----------------------------------------------------------------------------
// dice_roll_capture
//   Sits between a debounced roll button and the display. While a roll is
//   requested it enables the external dice counter for at least
//   MIN_ROLL_CYCLES cycles. On release it freezes the counter, captures its
//   face and holds the result on screen for HOLD_CYCLES cycles. It also keeps
//   a saturating roll count and flags doubles and invalid faces.
//
// Parameters
//   MIN_ROLL_CYCLES : minimum cycles spent spinning (>= 1)
//   HOLD_CYCLES     : cycles the result is shown, roll ignored (>= 1)
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   roll         : roll request level (synchronous to clk)
//   num[2:0]     : dice counter output, valid faces 1..6
//   en           : counter enable (registered)
//   result[2:0]  : last valid captured face, 0 = none yet
//   result_valid : one-cycle pulse on a valid capture
//   err          : one-cycle pulse on an invalid capture (num 0 or 7)
//   double       : last two valid results were equal
//   roll_count   : number of valid captures, saturates at 255
//   seg[6:0]     : active-high segments {g,f,e,d,c,b,a} for result
//   busy         : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dice_roll_capture #(
   parameter int unsigned MIN_ROLL_CYCLES = 8,
   parameter int unsigned HOLD_CYCLES     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       roll,
   input  logic [2:0] num,
   output logic       en,
   output logic [2:0] result,
   output logic       result_valid,
   output logic       err,
   output logic       double,
   output logic [7:0] roll_count,
   output logic [6:0] seg,
   output logic       busy
);

   localparam int unsigned CNT_MAX = (MIN_ROLL_CYCLES > HOLD_CYCLES) ?
                                     MIN_ROLL_CYCLES : HOLD_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROLLING,
      S_CAPTURE,
      S_SHOW
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_en;
   logic [2:0]       r_result;
   logic             r_result_valid;
   logic             r_err;
   logic             r_double;
   logic [7:0]       r_roll_count;

   logic             w_roll_done;
   logic             w_show_done;
   logic             w_capture;
   logic             w_face_ok;
   logic             w_busy;
   logic [6:0]       w_seg;

   assign w_roll_done = (r_cnt == CNT_W'(MIN_ROLL_CYCLES - 1));
   assign w_show_done = (r_cnt == CNT_W'(HOLD_CYCLES - 1));

   // --------------------------------------------------------------------------
   // State register. en is registered from the next state so that it rises on
   // the same edge that enters ROLLING and falls on the edge that leaves it.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_en    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_en    <= (w_state_next == S_ROLLING);
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (roll) w_state_next = S_ROLLING;
         end
         S_ROLLING: begin
            // An early release keeps spinning until the minimum is met.
            if (!roll && w_roll_done) w_state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_state_next = S_SHOW;
         end
         S_SHOW: begin
            if (w_show_done) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Output / control decode
   // --------------------------------------------------------------------------
   always_comb begin
      w_busy    = (r_state != S_IDLE);
      w_capture = (r_state == S_CAPTURE);
      w_face_ok = (num != 3'd0) && (num != 3'd7);
   end

   // --------------------------------------------------------------------------
   // Shared cycle counter: cleared on every state change, so it starts at 0
   // on entry to ROLLING and SHOW. Saturates while spinning.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_state_next != r_state) begin
         r_cnt <= '0;
      end else if (r_state == S_ROLLING) begin
         if (!w_roll_done) r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == S_SHOW) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Capture datapath. num is sampled at the exit edge of CAPTURE, one cycle
   // after en fell, so the counter is already frozen.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
         r_double       <= 1'b0;
         r_roll_count   <= '0;
      end else begin
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
         if (w_capture) begin
            if (w_face_ok) begin
               r_result       <= num;
               r_result_valid <= 1'b1;
               r_double       <= (r_roll_count != 8'd0) && (num == r_result);
               if (r_roll_count != 8'hFF) r_roll_count <= r_roll_count + 8'd1;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Seven-segment decode, {g,f,e,d,c,b,a}
   // --------------------------------------------------------------------------
   always_comb begin
      w_seg = 7'b0000000;
      unique case (r_result)
         3'd1:    w_seg = 7'b0000110;
         3'd2:    w_seg = 7'b1011011;
         3'd3:    w_seg = 7'b1001111;
         3'd4:    w_seg = 7'b1100110;
         3'd5:    w_seg = 7'b1101101;
         3'd6:    w_seg = 7'b1111101;
         default: w_seg = 7'b0000000;
      endcase
   end

   assign en           = r_en;
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign err          = r_err;
   assign double       = r_double;
   assign roll_count   = r_roll_count;
   assign seg          = w_seg;
   assign busy         = w_busy;

endmodule

// File: tb/tb_dice_roll_capture.sv
module tb_dice_roll_capture;

  logic       clk;
  logic       reset;
  logic       roll;
  logic [2:0] num;
  logic       en;
  logic [2:0] result;
  logic       result_valid;
  logic       err;
  logic       double;
  logic [7:0] roll_count;
  logic [6:0] seg;
  logic       busy;

  int checks = 0;
  int errors = 0;

  dice_roll_capture #(
    .MIN_ROLL_CYCLES (4),
    .HOLD_CYCLES     (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .roll         (roll),
    .num          (num),
    .en           (en),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .double       (double),
    .roll_count   (roll_count),
    .seg          (seg),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    errors++;
    $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic roll_face(input int hold, input logic [2:0] face, output int en_hi);
    int guard;
    num   = face;
    roll  = 1'b1;
    en_hi = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (en) en_hi++;
    end
    roll  = 1'b0;
    guard = 0;
    while (en && guard < 64) begin
      tick();
      if (en) en_hi++;
      guard++;
    end
    checks++; if (!(guard < 64)) fail("spin_bounded", guard, 64);
    tick();
  endtask

  task automatic wait_idle();
    tick();
    tick();
    tick();
  endtask

  task automatic finish_show();
    tick();
    checks++; if (result_valid !== 1'b0) fail("rv_one_cycle", result_valid, 0);
    checks++; if (err !== 1'b0) fail("err_one_cycle", err, 0);
    tick();
    checks++; if (busy !== 1'b1) fail("busy_in_show", busy, 1);
    tick();
    checks++; if (busy !== 1'b0) fail("busy_fall", busy, 0);
  endtask

  initial begin
    int eh;
    int gap;
    int guard;

    reset = 1'b1;
    roll  = 1'b0;
    num   = 3'd0;

    tick();
    tick();
    reset = 1'b0;
    checks++; if (en !== 1'b0) fail("rst_en", en, 0);
    checks++; if (result !== 3'd0) fail("rst_result", result, 0);
    checks++; if (result_valid !== 1'b0) fail("rst_rv", result_valid, 0);
    checks++; if (err !== 1'b0) fail("rst_err", err, 0);
    checks++; if (double !== 1'b0) fail("rst_double", double, 0);
    checks++; if (roll_count !== 8'd0) fail("rst_count", roll_count, 0);
    checks++; if (seg !== 7'b0000000) fail("rst_seg", seg, 0);
    checks++; if (busy !== 1'b0) fail("rst_busy", busy, 0);
    tick();
    checks++; if (en !== 1'b0) fail("idle_en", en, 0);
    checks++; if (busy !== 1'b0) fail("idle_busy", busy, 0);

    roll_face(10, 3'd3, eh);
    checks++; if (eh != 10) fail("norm_en_len", eh, 10);
    checks++; if (result !== 3'd3) fail("norm_result", result, 3);
    checks++; if (seg !== 7'b1001111) fail("norm_seg", seg, 7'b1001111);
    checks++; if (result_valid !== 1'b1) fail("norm_rv", result_valid, 1);
    checks++; if (err !== 1'b0) fail("norm_err", err, 0);
    checks++; if (roll_count !== 8'd1) fail("norm_count", roll_count, 1);
    checks++; if (double !== 1'b0) fail("norm_double", double, 0);
    checks++; if (en !== 1'b0) fail("norm_en_off", en, 0);
    finish_show();

    roll_face(1, 3'd6, eh);
    checks++; if (eh != 4) fail("short_en_len", eh, 4);
    checks++; if (result !== 3'd6) fail("short_result", result, 6);
    checks++; if (seg !== 7'b1111101) fail("short_seg", seg, 7'b1111101);
    checks++; if (roll_count !== 8'd2) fail("short_count", roll_count, 2);
    finish_show();

    roll_face(2, 3'd5, eh);
    checks++; if (result !== 3'd5) fail("dbl1_result", result, 5);
    checks++; if (seg !== 7'b1101101) fail("dbl1_seg", seg, 7'b1101101);
    checks++; if (double !== 1'b0) fail("dbl1_double", double, 0);
    finish_show();
    roll_face(6, 3'd5, eh);
    checks++; if (eh != 6) fail("dbl2_en_len", eh, 6);
    checks++; if (double !== 1'b1) fail("dbl2_double", double, 1);
    checks++; if (roll_count !== 8'd4) fail("dbl2_count", roll_count, 4);
    finish_show();
    roll_face(1, 3'd2, eh);
    checks++; if (double !== 1'b0) fail("dbl3_double", double, 0);
    checks++; if (seg !== 7'b1011011) fail("dbl3_seg", seg, 7'b1011011);
    checks++; if (roll_count !== 8'd5) fail("dbl3_count", roll_count, 5);
    finish_show();
    roll_face(1, 3'd2, eh);
    checks++; if (double !== 1'b1) fail("dbl4_double", double, 1);
    checks++; if (roll_count !== 8'd6) fail("dbl4_count", roll_count, 6);
    finish_show();

    roll_face(1, 3'd7, eh);
    checks++; if (err !== 1'b1) fail("inv7_err", err, 1);
    checks++; if (result_valid !== 1'b0) fail("inv7_rv", result_valid, 0);
    checks++; if (result !== 3'd2) fail("inv7_result", result, 2);
    checks++; if (seg !== 7'b1011011) fail("inv7_seg", seg, 7'b1011011);
    checks++; if (roll_count !== 8'd6) fail("inv7_count", roll_count, 6);
    checks++; if (double !== 1'b1) fail("inv7_double", double, 1);
    finish_show();
    roll_face(1, 3'd0, eh);
    checks++; if (err !== 1'b1) fail("inv0_err", err, 1);
    checks++; if (result_valid !== 1'b0) fail("inv0_rv", result_valid, 0);
    checks++; if (result !== 3'd2) fail("inv0_result", result, 2);
    checks++; if (roll_count !== 8'd6) fail("inv0_count", roll_count, 6);
    checks++; if (double !== 1'b1) fail("inv0_double", double, 1);
    finish_show();

    num  = 3'd4;
    roll = 1'b1;
    tick();
    checks++; if (en !== 1'b1) fail("held_en_on", en, 1);
    roll  = 1'b0;
    guard = 0;
    while (en && guard < 64) begin
      tick();
      guard++;
    end
    checks++; if (!(guard < 64)) fail("held_spin_bounded", guard, 64);
    roll  = 1'b1;
    gap   = 1;
    guard = 0;
    while (guard < 64) begin
      tick();
      guard++;
      if (en) break;
      gap++;
    end
    checks++; if (gap != 5) fail("held_gap", gap, 5);
    checks++; if (roll_count !== 8'd7) fail("held_count_mid", roll_count, 7);
    checks++; if (result !== 3'd4) fail("held_result_mid", result, 4);
    tick();
    tick();
    roll  = 1'b0;
    guard = 0;
    while (en && guard < 64) begin
      tick();
      guard++;
    end
    checks++; if (!(guard < 64)) fail("held_spin2_bounded", guard, 64);
    tick();
    checks++; if (result_valid !== 1'b1) fail("held_rv", result_valid, 1);
    checks++; if (double !== 1'b1) fail("held_double", double, 1);
    checks++; if (roll_count !== 8'd8) fail("held_count", roll_count, 8);
    finish_show();

    for (int i = 0; i < 250; i++) begin
      roll_face(1, 3'((i % 6) + 1), eh);
      wait_idle();
    end
    checks++; if (roll_count !== 8'd255) fail("sat_count", roll_count, 255);
    checks++; if (result !== 3'd4) fail("sat_result", result, 4);
    roll_face(1, 3'd1, eh);
    checks++; if (result_valid !== 1'b1) fail("sat1_rv", result_valid, 1);
    checks++; if (double !== 1'b0) fail("sat1_double", double, 0);
    checks++; if (seg !== 7'b0000110) fail("sat1_seg", seg, 7'b0000110);
    checks++; if (roll_count !== 8'd255) fail("sat1_count", roll_count, 255);
    wait_idle();
    roll_face(1, 3'd1, eh);
    checks++; if (double !== 1'b1) fail("sat2_double", double, 1);
    checks++; if (roll_count !== 8'd255) fail("sat2_count", roll_count, 255);
    wait_idle();
    roll_face(1, 3'd3, eh);
    checks++; if (double !== 1'b0) fail("sat3_double", double, 0);
    checks++; if (roll_count !== 8'd255) fail("sat3_count", roll_count, 255);
    wait_idle();

    num  = 3'd3;
    roll = 1'b1;
    tick();
    tick();
    checks++; if (en !== 1'b1) fail("mid_en_on", en, 1);
    checks++; if (busy !== 1'b1) fail("mid_busy_on", busy, 1);
    #2 reset = 1'b1;
    #1;
    checks++; if (en !== 1'b0) fail("mid_en_async", en, 0);
    checks++; if (busy !== 1'b0) fail("mid_busy", busy, 0);
    checks++; if (result !== 3'd0) fail("mid_result", result, 0);
    checks++; if (roll_count !== 8'd0) fail("mid_count", roll_count, 0);
    checks++; if (double !== 1'b0) fail("mid_double", double, 0);
    checks++; if (seg !== 7'b0000000) fail("mid_seg", seg, 0);
    roll = 1'b0;
    #2 reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) fail("post_rst_busy", busy, 0);
    checks++; if (en !== 1'b0) fail("post_rst_en", en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
